dma_copy: RTL and testbench

// Word-granular memory-to-memory copy engine for the simple system. It is the initiator

---
 rtl/dma_pkg.sv | 37 +++
 rtl/dma_regs.sv | 92 +++++++++
 rtl/dma_copy.sv | 152 +++++++++++++++
 tb/tb_dma_copy.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copy engine: register map, control/status bit
// positions, FSM encoding and the byte-lane merge used by the register file.
package dma_pkg;

    localparam logic [9:0] DMA_SRC    = 10'h000;
    localparam logic [9:0] DMA_DST    = 10'h004;
    localparam logic [9:0] DMA_LEN    = 10'h008;
    localparam logic [9:0] DMA_CTRL   = 10'h00C;
    localparam logic [9:0] DMA_STATUS = 10'h010;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } dma_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dma_regs.sv
// Register file for dma_copy: SRC/DST/LEN/CTRL/STATUS, one-cycle response timing,
// byte-lane writes, W1C status bits and the registered interrupt.
module dma_regs
    import dma_pkg::*;
#(
    parameter int LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req,
    input  logic                we,
    input  logic [3:0]          be,
    input  logic [9:0]          offset,
    input  logic [31:0]         wdata,
    output logic                rvalid,
    output logic [31:0]         rdata,
    output logic                err,
    input  logic                busy,
    input  logic                done_set,
    input  logic                err_set,
    output logic [31:0]         src,
    output logic [31:0]         dst,
    output logic [LenWidth-1:0] len,
    output logic                start,
    output logic                abort,
    output logic                intr
);

    logic        hit, wr, ctrl_wr, stat_wr;
    logic        irq_en, done_q, err_q;
    logic [31:0] len_merged, rd_mux;
    logic        unused_len;

    assign hit     = offset inside {DMA_SRC, DMA_DST, DMA_LEN, DMA_CTRL, DMA_STATUS};
    assign wr      = req & we & hit;
    assign ctrl_wr = wr && (offset == DMA_CTRL) && be[0];
    assign stat_wr = wr && (offset == DMA_STATUS) && be[0];
    // A START seen while busy is dropped entirely, including its DONE/ERR clear.
    assign start   = ctrl_wr && wdata[CTRL_START] && !busy;
    assign abort   = ctrl_wr && wdata[CTRL_ABORT];

    assign len_merged = be_merge(32'(len), wdata, be);
    assign unused_len = ^len_merged;

    always_comb begin
        rd_mux = '0;
        case (offset)
            DMA_SRC:    rd_mux = src;
            DMA_DST:    rd_mux = dst;
            DMA_LEN:    rd_mux = 32'(len);
            DMA_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
            DMA_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done_q;
                rd_mux[STAT_ERR]  = err_q;
            end
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            irq_en <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            intr   <= 1'b0;
        end else begin
            rvalid <= req;
            err    <= req & ~hit;
            rdata  <= (req && !we) ? rd_mux : '0;

            if (wr && !busy) begin
                if (offset == DMA_SRC) src <= be_merge(src, wdata, be) & 32'hFFFF_FFFC;
                if (offset == DMA_DST) dst <= be_merge(dst, wdata, be) & 32'hFFFF_FFFC;
                if (offset == DMA_LEN) len <= len_merged[LenWidth-1:0];
            end
            if (ctrl_wr) irq_en <= wdata[CTRL_IRQ_EN];

            // Hardware set has priority over both START-clear and W1C.
            done_q <= done_set | (done_q & ~start & ~(stat_wr & wdata[STAT_DONE]));
            err_q  <= err_set  | (err_q  & ~start & ~(stat_wr & wdata[STAT_ERR]));
            intr   <= irq_en & (done_q | err_q);
        end
    end

endmodule

// File: rtl/dma_copy.sv
// Word-granular memory-to-memory copy engine: register slave port plus a bus master
// that performs one read then one write per word.
module dma_copy
    import dma_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int LenWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_req_i,
    input  logic                    dev_we_i,
    input  logic [3:0]              dev_be_i,
    input  logic [AddressWidth-1:0] dev_addr_i,
    input  logic [DataWidth-1:0]    dev_wdata_i,
    output logic                    dev_rvalid_o,
    output logic [DataWidth-1:0]    dev_rdata_o,
    output logic                    dev_err_o,
    output logic                    host_req_o,
    input  logic                    host_gnt_i,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic                    host_we_o,
    output logic [3:0]              host_be_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic                    host_rvalid_i,
    input  logic [DataWidth-1:0]    host_rdata_i,
    input  logic                    host_err_i,
    output logic                    dma_intr_o
);

    dma_state_e              state;
    logic [AddressWidth-1:0] cur_src, cur_dst;
    logic [LenWidth-1:0]     cnt, len;
    logic [31:0]             src, dst;
    logic                    abort_pend, start, abort, busy, done_set, err_set;
    logic                    unused_addr;

    assign unused_addr = ^dev_addr_i[AddressWidth-1:10];
    assign busy        = (state != IDLE);
    assign done_set    = (state == IDLE && start && len == '0) ||
                         (state == WR_WAIT && host_rvalid_i && !host_err_i && cnt == LenWidth'(1));
    assign err_set     = (state == RD_WAIT || state == WR_WAIT) && host_rvalid_i && host_err_i;

    dma_regs #(.LenWidth(LenWidth)) u_regs (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (dev_req_i),
        .we       (dev_we_i),
        .be       (dev_be_i),
        .offset   (dev_addr_i[9:0]),
        .wdata    (dev_wdata_i),
        .rvalid   (dev_rvalid_o),
        .rdata    (dev_rdata_o),
        .err      (dev_err_o),
        .busy     (busy),
        .done_set (done_set),
        .err_set  (err_set),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .start    (start),
        .abort    (abort),
        .intr     (dma_intr_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cur_src      <= '0;
            cur_dst      <= '0;
            cnt          <= '0;
            abort_pend   <= 1'b0;
            host_req_o   <= 1'b0;
            host_we_o    <= 1'b0;
            host_addr_o  <= '0;
            host_be_o    <= 4'h0;
            host_wdata_o <= '0;
        end else begin
            host_be_o <= 4'hF;
            if (abort && state != IDLE) abort_pend <= 1'b1;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (start && len != '0) begin
                        cur_src     <= AddressWidth'(src);
                        cur_dst     <= AddressWidth'(dst);
                        cnt         <= len;
                        host_req_o  <= 1'b1;
                        host_we_o   <= 1'b0;
                        host_addr_o <= AddressWidth'(src);
                        state       <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    // An ungranted read can be withdrawn; nothing is in flight yet.
                    if (host_gnt_i) begin
                        host_req_o <= 1'b0;
                        state      <= RD_WAIT;
                    end else if (abort_pend || abort) begin
                        host_req_o <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            abort_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            host_wdata_o <= host_rdata_i;
                            host_req_o   <= 1'b1;
                            host_we_o    <= 1'b1;
                            host_addr_o  <= cur_dst;
                            state        <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (host_gnt_i) begin
                        host_req_o <= 1'b0;
                        state      <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            abort_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            cur_src <= cur_src + AddressWidth'(4);
                            cur_dst <= cur_dst + AddressWidth'(4);
                            cnt     <= cnt - LenWidth'(1);
                            if (cnt == LenWidth'(1) || abort_pend || abort) begin
                                abort_pend <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                host_req_o  <= 1'b1;
                                host_we_o   <= 1'b0;
                                host_addr_o <= cur_src + AddressWidth'(4);
                                state       <= RD_REQ;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy with a one-cycle-response bus memory model.
module tb_dma_copy;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dev_req = 1'b0, dev_we = 1'b0;
    logic [3:0]  dev_be = 4'h0;
    logic [31:0] dev_addr = '0, dev_wdata = '0;
    logic        dev_rvalid, dev_err;
    logic [31:0] dev_rdata;
    logic        host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [3:0]  host_be;
    logic        intr;

    logic        gnt_allow = 1'b1;
    int          err_rd_at = 0;
    int          req_cycles = 0;
    logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;
    assign host_gnt = host_req & gnt_allow;

    dma_copy dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dev_req_i(dev_req), .dev_we_i(dev_we), .dev_be_i(dev_be), .dev_addr_i(dev_addr),
        .dev_wdata_i(dev_wdata), .dev_rvalid_o(dev_rvalid), .dev_rdata_o(dev_rdata),
        .dev_err_o(dev_err), .host_req_o(host_req), .host_gnt_i(host_gnt),
        .host_addr_o(host_addr), .host_we_o(host_we), .host_be_o(host_be),
        .host_wdata_o(host_wdata), .host_rvalid_i(host_rvalid), .host_rdata_i(host_rdata),
        .host_err_i(host_err), .dma_intr_o(intr)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + 32'd7;
    endfunction

    // Bus memory: reads return pat(addr); writes are logged.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            host_err    <= 1'b0;
        end else begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            host_err    <= 1'b0;
            if (host_req) req_cycles <= req_cycles + 1;
            if (host_req && host_gnt) begin
                host_rvalid <= 1'b1;
                if (host_we) begin
                    wr_addr_q.push_back(host_addr);
                    wr_data_q.push_back(host_wdata);
                end else begin
                    host_rdata <= pat(host_addr);
                    if (rd_addr_q.size() + 1 == err_rd_at) host_err <= 1'b1;
                    rd_addr_q.push_back(host_addr);
                end
            end
        end
    end

    task automatic reg_acc(input logic we, input logic [9:0] off, input logic [31:0] wd,
                           input logic [3:0] be, output logic rv, output logic [31:0] rd,
                           output logic er);
        dev_req = 1'b1; dev_we = we; dev_be = be;
        dev_addr = 32'h0003_0000 | {22'h0, off}; dev_wdata = wd;
        @(posedge clk); #1;
        dev_req = 1'b0; dev_we = 1'b0;
        rv = dev_rvalid; rd = dev_rdata; er = dev_err;
    endtask

    task automatic wr(input logic [9:0] off, input logic [31:0] wd);
        logic rv, er; logic [31:0] rd;
        reg_acc(1'b1, off, wd, 4'hF, rv, rd, er);
    endtask

    task automatic rd(input logic [9:0] off, output logic [31:0] d);
        logic rv, er;
        reg_acc(1'b0, off, 32'h0, 4'hF, rv, d, er);
    endtask

    task automatic wait_idle(output logic timeout);
        logic [31:0] s;
        timeout = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rd(10'h010, s);
            if (!s[0]) begin timeout = 1'b0; break; end
        end
    endtask

    task automatic wait_reads(input int target, output logic timeout);
        timeout = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (rd_addr_q.size() >= target) begin timeout = 1'b0; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] a, b, c, d, e;
        if ({host_req, host_we, host_be, host_addr, host_wdata, dev_rvalid, dev_rdata, dev_err, intr} !== '0) begin
            failures++; $display("FAIL reset_outputs: got nonzero output req=%b be=%h intr=%b", host_req, host_be, intr);
        end
        checks++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(10'h000, a); rd(10'h004, b); rd(10'h008, c); rd(10'h00C, d); rd(10'h010, e);
        if ({a, b, c, d, e} !== '0) begin
            failures++; $display("FAIL reset_regs: got %h %h %h %h %h want all 0", a, b, c, d, e);
        end
        checks++;
    endtask

    task automatic test_copy();
        logic to; logic [31:0] s, x; logic rv, er;
        int w0 = wr_addr_q.size(), r0 = rd_addr_q.size();
        logic ok = 1'b1;
        wr(10'h000, 32'h0010_0000); wr(10'h004, 32'h0010_0400); wr(10'h008, 32'd4);
        wr(10'h00C, 32'h1);
        wait_idle(to);
        if (to !== 1'b0) begin failures++; $display("FAIL copy_timeout: busy never cleared"); end
        checks++;
        if (wr_addr_q.size() - w0 != 4 || rd_addr_q.size() - r0 != 4) begin
            failures++; $display("FAIL copy_count: got rd=%0d wr=%0d want 4/4", rd_addr_q.size() - r0, wr_addr_q.size() - w0);
        end else begin
            for (int i = 0; i < 4; i++)
                if (wr_addr_q[w0+i] !== 32'h0010_0400 + 32'(4*i) || wr_data_q[w0+i] !== pat(32'h0010_0000 + 32'(4*i)))
                    ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL copy_data: dst words differ from src"); end
        checks++;
        rd(10'h010, s);
        if (s !== 32'h2 || intr !== 1'b0 || host_be !== 4'hF) begin
            failures++; $display("FAIL copy_status: got status=%h intr=%b be=%h want 2/0/F", s, intr, host_be);
        end
        checks++;
        wr(10'h00C, 32'h2);
        rd(10'h010, s);
        if (intr !== 1'b1) begin failures++; $display("FAIL copy_irq: got intr=%b want 1", intr); end
        checks++;
        wr(10'h010, 32'h2);
        rd(10'h010, s);
        if (s !== 32'h0 || intr !== 1'b0) begin
            failures++; $display("FAIL copy_w1c: got status=%h intr=%b want 0/0", s, intr);
        end
        checks++;
        wr(10'h000, 32'h0010_0003);
        rd(10'h000, s);
        reg_acc(1'b1, 10'h008, 32'h0000_ABCD, 4'b0010, rv, x, er);
        rd(10'h008, x);
        if (s !== 32'h0010_0000 || x !== 32'h0000_AB04) begin
            failures++; $display("FAIL copy_regbits: got src=%h len=%h want 00100000/0000ab04", s, x);
        end
        checks++;
    endtask

    task automatic test_len_zero();
        logic [31:0] s; int rq0;
        wr(10'h008, 32'h0);
        rq0 = req_cycles;
        wr(10'h00C, 32'h3);
        rd(10'h010, s);
        if (s !== 32'h2 || intr !== 1'b1) begin
            failures++; $display("FAIL len0_done: got status=%h intr=%b want 2/1", s, intr);
        end
        checks++;
        repeat (3) @(posedge clk);
        #1;
        if (req_cycles != rq0) begin
            failures++; $display("FAIL len0_noreq: got %0d req cycles want 0", req_cycles - rq0);
        end
        checks++;
        wr(10'h010, 32'h2); wr(10'h00C, 32'h0);
    endtask

    task automatic test_gnt_stall();
        logic to; logic bad = 1'b0;
        int w0 = wr_addr_q.size(), r0 = rd_addr_q.size();
        gnt_allow = 1'b0;
        wr(10'h000, 32'h0010_0010); wr(10'h004, 32'h0010_0500); wr(10'h008, 32'd1);
        wr(10'h00C, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (host_req !== 1'b1 || host_we !== 1'b0 || host_addr !== 32'h0010_0010) bad = 1'b1;
            @(posedge clk); #1;
        end
        if (bad !== 1'b0) begin
            failures++; $display("FAIL stall_stable: got req=%b we=%b addr=%h want 1/0/00100010", host_req, host_we, host_addr);
        end
        checks++;
        gnt_allow = 1'b1;
        wait_idle(to);
        if (to !== 1'b0 || rd_addr_q.size() - r0 != 1 || wr_addr_q.size() - w0 != 1) begin
            failures++; $display("FAIL stall_count: got rd=%0d wr=%0d timeout=%b want 1/1/0", rd_addr_q.size() - r0, wr_addr_q.size() - w0, to);
        end else if (wr_data_q[w0] !== pat(32'h0010_0010)) begin
            failures++; $display("FAIL stall_data: got %h want %h", wr_data_q[w0], pat(32'h0010_0010));
        end
        checks++;
    endtask

    task automatic test_bus_error();
        logic to; logic [31:0] s;
        int w0 = wr_addr_q.size();
        err_rd_at = rd_addr_q.size() + 2;
        wr(10'h000, 32'h0010_0000); wr(10'h004, 32'h0010_0800); wr(10'h008, 32'd4);
        wr(10'h00C, 32'h1);
        wait_idle(to);
        err_rd_at = 0;
        rd(10'h010, s);
        if (to !== 1'b0 || s !== 32'h4) begin
            failures++; $display("FAIL err_status: got status=%h timeout=%b want 4/0", s, to);
        end
        checks++;
        if (wr_addr_q.size() - w0 != 1) begin
            failures++; $display("FAIL err_writes: got %0d want 1", wr_addr_q.size() - w0);
        end
        checks++;
        wr(10'h010, 32'h4);
        rd(10'h010, s);
        if (s !== 32'h0) begin failures++; $display("FAIL err_w1c: got %h want 0", s); end
        checks++;
    endtask

    task automatic test_abort();
        logic to, to2; logic [31:0] s, a;
        int w0 = wr_addr_q.size(), r0 = rd_addr_q.size();
        wr(10'h000, 32'h0010_0000); wr(10'h004, 32'h0010_0C00); wr(10'h008, 32'd8);
        wr(10'h00C, 32'h1);
        wr(10'h000, 32'h0020_0000);
        wr(10'h00C, 32'h1);
        wait_reads(r0 + 3, to);
        wr(10'h00C, 32'h4);
        wait_idle(to2);
        if (to !== 1'b0 || to2 !== 1'b0 || wr_addr_q.size() - w0 != 3 || rd_addr_q.size() - r0 != 3) begin
            failures++; $display("FAIL abort_count: got rd=%0d wr=%0d want 3/3", rd_addr_q.size() - r0, wr_addr_q.size() - w0);
        end
        checks++;
        rd(10'h010, s);
        rd(10'h000, a);
        if (s !== 32'h0 || a !== 32'h0010_0000) begin
            failures++; $display("FAIL abort_status: got status=%h src=%h want 0/00100000", s, a);
        end
        checks++;
    endtask

    task automatic test_edges();
        logic to, rv, er; logic [31:0] s; int r0;
        reg_acc(1'b0, 10'h020, 32'h0, 4'hF, rv, s, er);
        if (rv !== 1'b1 || er !== 1'b1 || s !== 32'h0) begin
            failures++; $display("FAIL unmapped: got rvalid=%b err=%b rdata=%h want 1/1/0", rv, er, s);
        end
        checks++;
        r0 = rd_addr_q.size();
        wr(10'h000, 32'hFFFF_FFFC); wr(10'h004, 32'h0000_0800); wr(10'h008, 32'd2);
        wr(10'h00C, 32'h1);
        wait_idle(to);
        if (to !== 1'b0 || rd_addr_q.size() - r0 != 2) begin
            failures++; $display("FAIL wrap_count: got %0d reads want 2", rd_addr_q.size() - r0);
        end else if (rd_addr_q[r0] !== 32'hFFFF_FFFC || rd_addr_q[r0+1] !== 32'h0) begin
            failures++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", rd_addr_q[r0], rd_addr_q[r0+1]);
        end
        checks++;
        wr(10'h010, 32'h6);
        r0 = rd_addr_q.size();
        wr(10'h000, 32'h0010_0000); wr(10'h004, 32'h0010_0400); wr(10'h008, 32'd8);
        wr(10'h00C, 32'h3);
        wait_reads(r0 + 1, to);
        rst_n = 1'b0;
        #1;
        if (to !== 1'b0 || {host_req, host_we, host_be, host_addr, host_wdata, dev_rvalid, dev_rdata, dev_err, intr} !== '0) begin
            failures++; $display("FAIL midreset: got req=%b we=%b addr=%h intr=%b want all 0", host_req, host_we, host_addr, intr);
        end
        checks++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        rd(10'h010, s);
        if (s !== 32'h0) begin failures++; $display("FAIL midreset_status: got %h want 0", s); end
        checks++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_copy();
        test_len_zero();
        test_gnt_stall();
        test_bus_error();
        test_abort();
        test_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
